led_sweep: RTL and testbench
============================

LED_SWEEP -- requirements
Module: led_sweep

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of LED channels.
REQ-002 SHALL have parameter CNT_W, default 32, free-running counter width.
REQ-003 SHALL have parameter EXP_W, default 5, divider-exponent width (2^EXP_W >= CNT_W).
REQ-004 SHALL have parameter STEP_W, default 4, steps-per-level field width.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, run enable; low freezes all state.
REQ-009 SHALL have port mode, input, 2, 0 fixed / 1 sweep-up / 2 sweep-down / 3 triangle.
REQ-010 SHALL have port exp_min, input, EXP_W, lowest exponent (fastest blink).
REQ-011 SHALL have port exp_max, input, EXP_W, highest exponent (slowest blink).
REQ-012 SHALL have port steps, input, STEP_W, rising edges of led_out[0] per level, minus 1.
REQ-013 SHALL have port led_out, output, N_CH, registered LED drives.
REQ-014 SHALL have port cur_exp, output, EXP_W, current level exponent.
REQ-015 SHALL have port lvl_stb, output, 1, one-cycle pulse on each level change.

Function
REQ-016 SHALL, while en=1, increment counter cnt by 1 per cycle, wrapping at 2^CNT_W-1 to 0.
REQ-017 SHALL use per-channel exponent e_i = min(cur_exp + i, CNT_W-1), computed at EXP_W+1 bits so the sum cannot overflow.
REQ-018 SHALL register led_out[i] <= cnt[e_i], so led_out lags cnt by one cycle.
REQ-019 SHALL detect rising edges of led_out[0] synchronously, by comparison with its previous-cycle value; no clocking from derived signals.
REQ-020 SHALL increment step_cnt on each detected edge, and on the edge where step_cnt == steps SHALL advance the level and clear step_cnt (steps=0 advances on every edge).
REQ-021 SHALL advance per mode: mode 0 holds cur_exp = exp_min, never advances, lvl_stb stays 0; mode 1 goes +1, wrapping exp_max -> exp_min; mode 2 goes -1, wrapping exp_min -> exp_max; mode 3 moves in direction dir and reverses dir on reaching exp_max or exp_min.
REQ-022 SHALL assert lvl_stb for exactly the cycle in which cur_exp takes its new value.
REQ-023 SHALL clamp both bounds to CNT_W-1 before use.
REQ-024 SHALL, if clamped exp_min >= exp_max, hold cur_exp = exp_min with no advances.
REQ-025 SHALL, on a cycle where cur_exp is outside [exp_min, exp_max] (live config change), load cur_exp the next cycle with exp_max in mode 2 and exp_min otherwise, clear step_cnt, set dir up, and pulse lvl_stb; this takes priority over a simultaneous edge advance.
REQ-026 SHALL, on a mode change, keep cur_exp; the new mode applies from the next advance.
REQ-027 SHALL, while en=0, hold cnt, led_out, step_cnt, cur_exp and dir, and keep lvl_stb at 0.

Reset
REQ-028 SHALL, on reset=1 at a clk edge, set cnt=0, led_out=0, step_cnt=0, dir=up, lvl_stb=0 and cur_exp=clamped exp_min; reset overrides en and all other inputs.
REQ-029 SHALL restart cleanly when reset is applied mid-sweep, with no residual step count.

Configuration
REQ-030 SHALL provide a macro LED_SWEEP_TRIANGLE_EN: when defined, mode 3 is triangle per REQ-021; when undefined, mode 3 behaves exactly as mode 1 and the dir register is not instantiated.

Structure
REQ-031 SHALL place the mode encodings (MODE_FIXED, MODE_UP, MODE_DOWN, MODE_TRI) and the dir encoding in shared package led_sweep_pkg.
REQ-032 SHALL implement the step_cnt/cur_exp/dir state machine in sub-module led_sweep_ctrl; cnt and the led_out registers stay in the top module.

Verification
REQ-033 SHALL cover: N_CH=2, mode=1, exp_min=2, exp_max=4, steps=0 -> led_out[0] period 8, 16, 32, 8...; led_out[1] at twice led_out[0]'s period; lvl_stb once per level.
REQ-034 SHALL cover: mode=3, exp_min=1, exp_max=3, steps=1 -> cur_exp 1,2,3,2,1,2; two led_out[0] rising edges per level.
REQ-035 SHALL cover: mode=2 at cur_exp=2, then exp_max changed to 1 -> next cycle cur_exp=1 (exp_max), lvl_stb=1, step_cnt=0.
REQ-036 SHALL cover: exp_min=5, exp_max=5, mode=1 for 1000 cycles -> cur_exp fixed at 5, lvl_stb never asserted.
REQ-037 SHALL cover: en=0 for 10 cycles mid-level -> all outputs constant, sweep resumes from the same cnt; then reset=1 with en=1 -> next cycle all reset values per REQ-028.
REQ-038 SHALL cover: CNT_W=8, exp_max=20, N_CH=4 -> all e_i clamp at 7, no X values, cnt wraps 255 -> 0.

Source files
------------

// File: rtl/led_sweep_pkg.sv
// Shared encodings for the LED sweep block: operating modes and triangle direction.
package led_sweep_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_UP    = 2'd1,
      MODE_DOWN  = 2'd2,
      MODE_TRI   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_sweep_ctrl.sv
// Level sequencer: counts led_out[0] rising edges and steps cur_exp through [exp_min, exp_max].
// LED_SWEEP_TRIANGLE_EN adds the bouncing triangle mode and its direction register.
module led_sweep_ctrl
   import led_sweep_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int EXP_W  = 5,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [EXP_W-1:0]  exp_min,
   input  logic [EXP_W-1:0]  exp_max,
   input  logic [STEP_W-1:0] steps,
   input  logic              led0,
   output logic [EXP_W-1:0]  cur_exp,
   output logic              lvl_stb
);

   localparam logic [EXP_W-1:0] MAX_E = EXP_W'(CNT_W - 1);

   mode_e             mode_w;
   logic [EXP_W-1:0]  lo, hi, cur_q, cur_d, adv_exp;
   logic [STEP_W-1:0] step_q, step_d;
   logic              stb_q, stb_d, led0_prev_q, rise;

   assign mode_w = mode_e'(mode);
   assign lo     = (exp_min > MAX_E) ? MAX_E : exp_min;
   assign hi     = (exp_max > MAX_E) ? MAX_E : exp_max;
   assign rise   = led0 & ~led0_prev_q;

`ifdef LED_SWEEP_TRIANGLE_EN
   dir_e             dir_q, dir_d;
   logic             go_up;
   logic [EXP_W-1:0] tri_exp;

   // Turn around when pinned at a bound so a stale direction never leaves the range.
   assign go_up   = ((dir_q == DIR_UP) && (cur_q < hi)) || ((dir_q == DIR_DOWN) && (cur_q <= lo));
   assign tri_exp = go_up ? cur_q + 1'b1 : cur_q - 1'b1;

   always_ff @(posedge clk) begin
      if (reset)   dir_q <= DIR_UP;
      else if (en) dir_q <= dir_d;
   end
`endif

   always_comb begin
      case (mode_w)
         MODE_DOWN: adv_exp = (cur_q == lo) ? hi : cur_q - 1'b1;
`ifdef LED_SWEEP_TRIANGLE_EN
         MODE_TRI:  adv_exp = tri_exp;
`endif
         default:   adv_exp = (cur_q == hi) ? lo : cur_q + 1'b1;
      endcase
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      cur_d  = cur_q;
      step_d = step_q;
      stb_d  = 1'b0;
`ifdef LED_SWEEP_TRIANGLE_EN
      dir_d  = dir_q;
`endif
      if (mode_w == MODE_FIXED) begin
         cur_d  = lo;
         step_d = '0;
      end else if (lo >= hi) begin
         step_d = '0;
         if (cur_q != lo) begin
            cur_d = lo;
            stb_d = 1'b1;
`ifdef LED_SWEEP_TRIANGLE_EN
            dir_d = DIR_UP;
`endif
         end
      end else if ((cur_q < lo) || (cur_q > hi)) begin
         cur_d  = (mode_w == MODE_DOWN) ? hi : lo;
         step_d = '0;
         stb_d  = 1'b1;
`ifdef LED_SWEEP_TRIANGLE_EN
         dir_d  = DIR_UP;
`endif
      end else if (rise) begin
         if (step_q == steps) begin
            step_d = '0;
            cur_d  = adv_exp;
            stb_d  = 1'b1;
`ifdef LED_SWEEP_TRIANGLE_EN
            if (mode_w == MODE_TRI)
               dir_d = (tri_exp >= hi) ? DIR_DOWN :
                       (tri_exp <= lo) ? DIR_UP   :
                       (go_up ? DIR_UP : DIR_DOWN);
`endif
         end else begin
            step_d = step_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q       <= lo;
         step_q      <= '0;
         stb_q       <= 1'b0;
         led0_prev_q <= 1'b0;
      end else if (en) begin
         cur_q       <= cur_d;
         step_q      <= step_d;
         stb_q       <= stb_d;
         led0_prev_q <= led0;
      end else begin
         // A strobe is a single-cycle event, so a frozen block must not repeat it.
         stb_q <= 1'b0;
      end
   end

   assign cur_exp = cur_q;
   assign lvl_stb = stb_q;

endmodule

// File: rtl/led_sweep.sv
// LED sweep top: free-running counter and per-channel LED taps; sequencing lives in led_sweep_ctrl.
// Build option: define LED_SWEEP_TRIANGLE_EN to enable the triangle mode (mode 3).
module led_sweep
   import led_sweep_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 32,
   parameter int EXP_W  = 5,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [EXP_W-1:0]  exp_min,
   input  logic [EXP_W-1:0]  exp_max,
   input  logic [STEP_W-1:0] steps,
   output logic [N_CH-1:0]   led_out,
   output logic [EXP_W-1:0]  cur_exp,
   output logic              lvl_stb
);

   localparam int CNT_IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [N_CH-1:0]  led_q, led_d;

   // Channel i taps bit cur_exp+i, widened by one bit so the sum cannot wrap before clamping.
   function automatic logic [CNT_IDX_W-1:0] chan_sel(input logic [EXP_W-1:0] e, input int i);
      logic [EXP_W:0] s;
      s = {1'b0, e} + (EXP_W + 1)'(i);
      if (s > (EXP_W + 1)'(CNT_W - 1)) s = (EXP_W + 1)'(CNT_W - 1);
      return CNT_IDX_W'(s);
   endfunction

   always_comb begin
      led_d = '0;
      for (int i = 0; i < N_CH; i++) led_d[i] = cnt_q[chan_sel(cur_exp, i)];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         led_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
         led_q <= led_d;
      end
   end

   led_sweep_ctrl #(
      .CNT_W  (CNT_W),
      .EXP_W  (EXP_W),
      .STEP_W (STEP_W)
   ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .exp_min (exp_min),
      .exp_max (exp_max),
      .steps   (steps),
      .led0    (led_q[0]),
      .cur_exp (cur_exp),
      .lvl_stb (lvl_stb)
   );

   assign led_out = led_q;

endmodule

// File: tb/tb_led_sweep.sv
// Self-checking bench for led_sweep: directed scenarios plus randomized segments against a behavioural model.
// Honours LED_SWEEP_TRIANGLE_EN the same way the design does.
module tb_led_sweep;

   localparam int NC = 4;
   localparam int CW = 8;
   localparam int EW = 5;
   localparam int SW = 4;
`ifdef LED_SWEEP_TRIANGLE_EN
   localparam bit TRI_EN = 1'b1;
`else
   localparam bit TRI_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, en;
   logic [1:0]    mode;
   logic [EW-1:0] exp_min, exp_max;
   logic [SW-1:0] steps;
   logic [NC-1:0] led_out;
   logic [EW-1:0] cur_exp;
   logic          lvl_stb;

   int total = 0;
   int bad   = 0;
   string phase = "init";

   // Behavioural reference state
   int m_cnt, m_prev0, m_step, m_exp, m_dir, m_stb;
   int m_led[NC];
   int stb_vals[$];

   always #5 clk = ~clk;

   led_sweep #(.N_CH(NC), .CNT_W(CW), .EXP_W(EW), .STEP_W(SW)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .exp_min (exp_min),
      .exp_max (exp_max),
      .steps   (steps),
      .led_out (led_out),
      .cur_exp (cur_exp),
      .lvl_stb (lvl_stb)
   );

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, expv);
      end
   endtask

   // One clock of the reference: all decisions use the values held before the edge.
   task automatic model_step();
      int lo, hi, rise, md, nxt;
      int nled[NC];
      if (reset) begin
         m_cnt = 0; m_prev0 = 0; m_step = 0; m_dir = 1; m_stb = 0;
         m_exp = imin(int'(exp_min), CW - 1);
         foreach (m_led[i]) m_led[i] = 0;
         return;
      end
      if (!en) begin
         m_stb = 0;
         return;
      end
      lo   = imin(int'(exp_min), CW - 1);
      hi   = imin(int'(exp_max), CW - 1);
      rise = (m_led[0] == 1 && m_prev0 == 0);
      for (int i = 0; i < NC; i++) nled[i] = (m_cnt >> imin(m_exp + i, CW - 1)) & 1;
      m_prev0 = m_led[0];
      m_cnt   = (m_cnt + 1) % (1 << CW);
      m_stb   = 0;
      md      = int'(mode);
      if (md == 3 && !TRI_EN) md = 1;
      if (md == 0) begin
         m_exp = lo; m_step = 0;
      end else if (lo >= hi) begin
         m_step = 0;
         if (m_exp != lo) begin m_exp = lo; m_stb = 1; m_dir = 1; end
      end else if (m_exp < lo || m_exp > hi) begin
         m_exp = (md == 2) ? hi : lo; m_step = 0; m_stb = 1; m_dir = 1;
      end else if (rise) begin
         if (m_step == int'(steps)) begin
            m_step = 0; m_stb = 1;
            case (md)
               1: m_exp = (m_exp == hi) ? lo : m_exp + 1;
               2: m_exp = (m_exp == lo) ? hi : m_exp - 1;
               default: begin
                  nxt = m_exp + m_dir;
                  if (nxt > hi || nxt < lo) begin m_dir = -m_dir; nxt = m_exp + m_dir; end
                  if (nxt == hi) m_dir = -1;
                  if (nxt == lo) m_dir = 1;
                  m_exp = nxt;
               end
            endcase
         end else begin
            m_step++;
         end
      end
      foreach (m_led[i]) m_led[i] = nled[i];
   endtask

   task automatic cycle();
      logic [NC-1:0] exp_led;
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NC; i++) exp_led[i] = m_led[i][0];
      check("led_out", 32'(led_out), 32'(exp_led));
      check("cur_exp", 32'(cur_exp), 32'(m_exp));
      check("lvl_stb", 32'(lvl_stb), 32'(m_stb));
      if (lvl_stb === 1'b1) stb_vals.push_back(int'(cur_exp));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      stb_vals.delete();
   endtask

   initial begin
      logic [NC-1:0] snap_led;
      logic [EW-1:0] snap_exp;
      int            k;
      int            exp_seq[5];
      reset = 1'b1; en = 1'b1; mode = 2'd1; exp_min = 5'd2; exp_max = 5'd4; steps = '0;

      // Sweep-up 2..4 with one edge per level; first strobes must be 3,4,2
      phase = "sweep_up";
      do_reset();
      check("rst_cur", 32'(cur_exp), 32'd2);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_stb", 32'(lvl_stb), 32'd0);
      run(300);
      check("up_nstb", 32'(stb_vals.size() >= 3), 32'd1);
      if (stb_vals.size() >= 3) begin
         check("up_lvl0", 32'(stb_vals[0]), 32'd3);
         check("up_lvl1", 32'(stb_vals[1]), 32'd4);
         check("up_lvl2", 32'(stb_vals[2]), 32'd2);
      end

      // Triangle 1..3, two edges per level
      phase = "triangle";
      mode = 2'd3; exp_min = 5'd1; exp_max = 5'd3; steps = 4'd1;
      do_reset();
      run(400);
      if (TRI_EN) exp_seq = '{2, 3, 2, 1, 2};
      else        exp_seq = '{2, 3, 1, 2, 3};
      check("tri_nstb", 32'(stb_vals.size() >= 5), 32'd1);
      if (stb_vals.size() >= 5)
         for (int i = 0; i < 5; i++) check($sformatf("tri_lvl%0d", i), 32'(stb_vals[i]), 32'(exp_seq[i]));

      // Sweep-down, then shrink exp_max below cur_exp
      phase = "live_cfg";
      mode = 2'd2; exp_min = 5'd0; exp_max = 5'd4; steps = '0;
      do_reset();
      k = 0;
      while (cur_exp !== 5'd2 && k < 2000) begin cycle(); k++; end
      check("wait_exp2", 32'(cur_exp), 32'd2);
      exp_max = 5'd1;
      cycle();
      check("reload_cur", 32'(cur_exp), 32'd1);
      check("reload_stb", 32'(lvl_stb), 32'd1);
      run(100);

      // Degenerate range: no advances for 1000 cycles
      phase = "equal_bounds";
      mode = 2'd1; exp_min = 5'd5; exp_max = 5'd5;
      do_reset();
      run(1000);
      check("eq_nstb", 32'(stb_vals.size()), 32'd0);
      check("eq_cur", 32'(cur_exp), 32'd5);

      // Freeze with en=0, resume, then reset mid-sweep
      phase = "freeze";
      mode = 2'd1; exp_min = 5'd2; exp_max = 5'd4; steps = 4'd2;
      do_reset();
      run(77);
      snap_led = led_out; snap_exp = cur_exp;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("frz_led", 32'(led_out), 32'(snap_led));
         check("frz_cur", 32'(cur_exp), 32'(snap_exp));
         check("frz_stb", 32'(lvl_stb), 32'd0);
      end
      en = 1'b1;
      run(150);
      exp_min = 5'd3;
      do_reset();
      check("mid_rst_cur", 32'(cur_exp), 32'd3);
      check("mid_rst_led", 32'(led_out), 32'd0);
      check("mid_rst_stb", 32'(lvl_stb), 32'd0);
      run(60);

      // Clamp of out-of-range bounds, several counter wraps
      phase = "clamp";
      mode = 2'd1; exp_min = 5'd3; exp_max = 5'd20; steps = '0;
      do_reset();
      run(900);

      // Randomized segments: live config changes, en gaps, occasional resets
      phase = "random";
      for (int s = 0; s < 20; s++) begin
         mode    = 2'($urandom_range(0, 3));
         exp_min = EW'($urandom_range(0, 9));
         exp_max = EW'($urandom_range(0, 9));
         steps   = SW'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            reset = 1'b1; cycle(); reset = 1'b0;
         end
         for (int c = 0; c < 200; c++) begin
            en = ($urandom_range(0, 9) != 0);
            cycle();
         end
      end
      en = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
